// File: rtl/uart_tx_sched_if.sv
// Producer-side bundle for uart_tx_sched.
//   req      : per-requester send request (level)
//   req_data : byte for requester i at [i*DATA_W +: DATA_W]
//   gnt      : one-hot grant pulse, one cycle
//   gnt_id   : index of the current or last grant
//   busy     : high from the grant cycle until the frame completes
//   done     : one-cycle pulse at frame completion
// Modports: master = producers, slave = scheduler.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [ID_W-1:0]           gnt_id;
    logic                      busy;
    logic                      done;

    modport master (
        output req, req_data,
        input  gnt, gnt_id, busy, done
    );

    modport slave (
        input  req, req_data,
        output gnt, gnt_id, busy, done
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler: shares one serial line between
// NUM_REQ byte producers. One requester is granted at a time and its byte
// is serialized LSB first, one bit per rising edge of baud_pulse.
//
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active low
//   baud_pulse : baud pulse (multi-cycle high); only its rising edge counts
//   bus        : producer bundle (req/req_data in, gnt/gnt_id/busy/done out)
//   tx         : serial line, idle high
//
// Optional feature: define UART_PARITY_EN to append an even parity bit
// after the data bits.
module uart_tx_sched #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             baud_pulse,
    uart_tx_sched_if.slave   bus,
    output logic             tx
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state_reg;
    logic                bp_q_reg;
    logic [DATA_W-1:0]   shreg_reg;
    logic [CNT_W-1:0]    bitcnt_reg;
    logic [1:0]          stopcnt_reg;
    logic [ID_W-1:0]     last_reg;
    logic [NUM_REQ-1:0]  gnt_reg;
    logic [ID_W-1:0]     gnt_id_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                tx_reg;
`ifdef UART_PARITY_EN
    logic                parity_reg;
`endif

    // bp_q resets high so a pulse already high at reset release is not a tick.
    logic tick;
    assign tick = baud_pulse & ~bp_q_reg;

    // Per-requester byte slices and one-hot decode of the selected index.
    logic [DATA_W-1:0]  req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0] pick_onehot;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_valid;
    logic [DATA_W-1:0]  pick_data;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_bytes[gi]   = bus.req_data[gi*DATA_W +: DATA_W];
            assign pick_onehot[gi] = (pick_idx == ID_W'(gi));
        end
    endgenerate

    assign pick_data = req_bytes[pick_idx];

    // Round-robin search starting just above the last grant. Scanning from
    // the farthest candidate down lets the nearest requester win last.
    logic [ID_W-1:0] cand;
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last_reg) + k) % NUM_REQ);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            bp_q_reg    <= 1'b1;
            shreg_reg   <= '0;
            bitcnt_reg  <= '0;
            stopcnt_reg <= '0;
            last_reg    <= ID_W'(NUM_REQ - 1);
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            tx_reg      <= 1'b1;
`ifdef UART_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            bp_q_reg <= baud_pulse;
            gnt_reg  <= '0;
            done_reg <= 1'b0;
            case (state_reg)
                // Ticks are ignored here, so a tick landing on the grant
                // cycle never starts the frame.
                S_IDLE: begin
                    if (pick_valid) begin
                        gnt_reg    <= pick_onehot;
                        shreg_reg  <= pick_data;
                        gnt_id_reg <= pick_idx;
                        last_reg   <= pick_idx;
                        busy_reg   <= 1'b1;
`ifdef UART_PARITY_EN
                        parity_reg <= ^pick_data;
`endif
                        state_reg  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tick) begin
                        tx_reg    <= 1'b0;
                        state_reg <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx_reg     <= shreg_reg[0];
                        shreg_reg  <= shreg_reg >> 1;
                        bitcnt_reg <= CNT_W'(1);
                        state_reg  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bitcnt_reg < CNT_W'(DATA_W)) begin
                            tx_reg     <= shreg_reg[0];
                            shreg_reg  <= shreg_reg >> 1;
                            bitcnt_reg <= bitcnt_reg + CNT_W'(1);
                        end else begin
`ifdef UART_PARITY_EN
                            // Parity occupies one bit slot; stop bits
                            // are then counted from zero.
                            tx_reg      <= parity_reg;
                            stopcnt_reg <= 2'd0;
`else
                            tx_reg      <= 1'b1;
                            stopcnt_reg <= 2'd1;
`endif
                            state_reg   <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (stopcnt_reg < 2'(STOP_BITS)) begin
                            tx_reg      <= 1'b1;
                            stopcnt_reg <= stopcnt_reg + 2'd1;
                        end else begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_reg;
    assign bus.gnt_id = gnt_id_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign tx         = tx_reg;
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares one UART serial line between `NUM_REQ` byte producers. Accepts byte requests, grants one requester at a time, and serializes the granted byte using the baud pulse from `baudgen` (`pulse_tx`). Sits between the producers and the TX pin, with `baudgen` as its only timing source.

## Interface
- `NUM_REQ`, 4: number of requesters, 2–8.
- `DATA_W`, 8: data bits per frame, 5–9.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset; synchronous, active-low.
- `baud_pulse`  in  1: `pulse_tx` from `baudgen`, multi-cycle high pulse; only its rising edge is used.
- `req`  in  `NUM_REQ`: per-requester send request, level.
- `req_data`  in  `NUM_REQ*DATA_W`: byte for requester i at bits `[i*DATA_W +: DATA_W]`.
- `gnt`  out  `NUM_REQ`: one-hot grant, 1-cycle pulse.
- `gnt_id`  out  `$clog2(NUM_REQ)`: index of the current or last grant.
- `busy`  out  1: high from the grant cycle until the frame completes.
- `done`  out  1: 1-cycle pulse at frame completion.
- `tx`  out  1: serial line, idle high.

## Operation
- Tick: `tick = baud_pulse & ~bp_q`, where `bp_q` is `baud_pulse` registered. `bp_q` resets to 1, so a pulse already high when reset is released produces no tick.
- FSM states: IDLE, WAIT, START, DATA, STOP.
- **IDLE:** if `req != 0`, grant the first set bit searching upward from `(last+1) mod NUM_REQ`.
  - In that same cycle: pulse `gnt[i]`, load `req_data[i]` into the shift register, set `gnt_id=i`, `last=i`, `busy=1`, and go to WAIT.
  - Ticks arriving while in IDLE are ignored.
- **WAIT:** on the next tick, drive `tx=0` (start bit) and go to START.
- **START:** on the next tick, drive `tx=shreg[0]`, shift right, set `bitcnt=1`, and go to DATA. Data is sent LSB first.
- **DATA:** on each tick:
  - If `bitcnt<DATA_W`, output the next bit and increment `bitcnt`.
  - Else drive `tx=1`, set `stopcnt=1`, and go to STOP.
- **STOP:** on each tick:
  - If `stopcnt<STOP_BITS`, keep `tx=1` and increment `stopcnt`.
  - Else pulse `done`, clear `busy`, and go to IDLE.
- Requester handshake:
  - Hold `req` high with stable data until `gnt[i]` is seen; data is sampled only in the grant cycle.
  - Dropping `req` before the grant withdraws the request with no side effects.
  - Keeping `req` high after the grant requests another frame.
- Round-robin: `last` resets to `NUM_REQ-1`, so requester 0 has priority first. The requester just served has the lowest priority for the next grant.
- Simultaneous events:
  - `done` and a pending `req` in the same cycle: the grant happens in the following cycle from IDLE. There is never a same-cycle re-grant.
  - A tick and the grant in the same cycle: that tick is not used; the start bit comes on the next tick.
- Reset while `rst=0`, taking effect at the clock edge: state IDLE, `tx=1`, `busy=0`, `gnt=0`, `done=0`, `gnt_id=0`, `last=NUM_REQ-1`, shift register and counters cleared.
  - A frame in progress when reset is asserted is abandoned, and the line returns high on that edge.

## Timing
- All outputs are registered.
- Grant latency: `gnt` is high in the cycle after `req` is first sampled high in IDLE.
- Start bit: begins on the first tick after the grant cycle.
- Frame length, from the start-bit tick to the `done` tick: `1+DATA_W+STOP_BITS` tick periods (`+1` with parity).
- Each bit lasts exactly one tick period. `tx` changes only on tick cycles, and is held high at all other times outside a frame.
- With the default `baudgen` (868 clk per tick): worst-case start latency ≈ 868 clk; frame length 10×868 clk.

## Configuration
- `UART_PARITY_EN` defined:
  - After the last data bit, on the next tick, drive `tx` = XOR of the `DATA_W` data bits (even parity), then enter STOP.
  - Frame length increases by one bit.
- Not defined: no parity bit; DATA goes directly to STOP.

## Test plan
- Single request: `req=4'b0001`, data `0x55`, `baud_pulse` stub with period 16 clk and width 4 -> `gnt=0001` one cycle later, `tx` sequence `0,1,0,1,0,1,0,1,0,1` at successive ticks, `done` at the 10th tick after start, `busy` then low.
- Round-robin: `req=4'b1111` held with data `0xA0`–`0xA3` -> grant order 0,1,2,3,0; each frame carries its own byte; no starvation.
- Withdrawal: requester 2 raises `req` and drops it before a grant while requester 1 is being served -> requester 2 is never granted and `gnt` never shows `0100`.
- Reset mid-frame: `rst=0` at the 4th data bit -> `tx=1`, `busy=0` on that edge; after release, requester 0 is granted first.
- Tick alignment: `baud_pulse` held high across reset release -> no frame bit until the next rising edge; a tick coinciding with the grant cycle is not used for the start bit.
- `UART_PARITY_EN`: data `0x07` -> parity bit 1 before the stop bit; frame length 11 ticks.
